// File: rtl/mod_addsub_serial.sv
// mod_addsub_serial
//   Limb-serial modular adder/subtractor for the ECC datapath.
//   Computes (A + B) mod M or (A - B) mod M, LIMB bits per cycle, in two
//   passes of NL = WIDTH/LIMB cycles each: raw add/sub, then modulus correction.
//   Result appears exactly 2*NL cycles after the accept edge.
//
// Parameters:
//   WIDTH  operand/modulus width (integer multiple of LIMB)
//   LIMB   bits processed per cycle
//
// Ports:
//   clk        clock, all state changes on rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set offered
//   in_ready   block accepts operands (IDLE only)
//   op_sub     0: A+B mod M, 1: A-B mod M (captured with operands)
//   opA/opB    operands, 0 <= A,B < M
//   opM        modulus, M > 0
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   out_data   result, held until the next result overwrites it
//   busy       high in PASS1, PASS2 and DONE
module mod_addsub_serial #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int NL = WIDTH / LIMB;
  localparam int CW = (NL > 1) ? $clog2(NL) : 1;
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS1,
    S_PASS2,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a, r_b, r_m;
  logic [WIDTH-1:0] r_s;      // raw sum/difference (low WIDTH bits)
  logic [WIDTH-1:0] r_t;      // corrected value, built limb by limb
  logic [WIDTH-1:0] r_out;
  logic             r_sub;
  logic             r_f;      // carry/borrow out of PASS1 (bit WIDTH of raw)
  logic             r_c;      // running carry/borrow between limbs
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic [IW-1:0]    w_base;
  logic [LIMB-1:0]  w_x, w_y;
  logic             w_do_sub;
  logic [LIMB:0]    w_res;
  logic [WIDTH-1:0] w_t_full;
  logic             w_take_t;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out;

  assign w_last = (r_cnt == CW'(NL - 1));
  assign w_base = IW'(32'(r_cnt) * 32'(LIMB));

  // One LIMB+1 bit adder serves both passes: PASS1 applies op_sub to A,B;
  // PASS2 applies the opposite operation to S,M. Top bit is carry or borrow.
  always_comb begin
    w_x      = '0;
    w_y      = '0;
    w_do_sub = 1'b0;
    w_res    = '0;
    w_t_full = r_t;
    w_take_t = 1'b0;
    if (r_state == S_PASS2) begin
      w_x      = r_s[w_base +: LIMB];
      w_y      = r_m[w_base +: LIMB];
      w_do_sub = !r_sub;
    end else begin
      w_x      = r_a[w_base +: LIMB];
      w_y      = r_b[w_base +: LIMB];
      w_do_sub = r_sub;
    end
    if (w_do_sub)
      w_res = {1'b0, w_x} - {1'b0, w_y} - {{LIMB{1'b0}}, r_c};
    else
      w_res = {1'b0, w_x} + {1'b0, w_y} + {{LIMB{1'b0}}, r_c};
    // Full T including the limb being computed this cycle.
    w_t_full[w_base +: LIMB] = w_res[LIMB-1:0];
    // add: raw >= M when F set or S-M did not borrow; sub: wrap when A<B.
    w_take_t = r_sub ? r_f : (r_f || !w_res[LIMB]);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_PASS1;
      S_PASS1: if (w_last)    w_next = S_PASS2;
      S_PASS2: if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_m   <= '0;
      r_s   <= '0;
      r_t   <= '0;
      r_out <= '0;
      r_sub <= 1'b0;
      r_f   <= 1'b0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= opA;
            r_b   <= opB;
            r_m   <= opM;
            r_sub <= op_sub;
            r_cnt <= '0;
            r_c   <= 1'b0;
          end
        end
        S_PASS1: begin
          r_s[w_base +: LIMB] <= w_res[LIMB-1:0];
          if (w_last) begin
            r_f   <= w_res[LIMB];
            r_c   <= 1'b0;
            r_cnt <= '0;
          end else begin
            r_c   <= w_res[LIMB];
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PASS2: begin
          r_t[w_base +: LIMB] <= w_res[LIMB-1:0];
          if (w_last) begin
            r_out <= w_take_t ? w_t_full : r_s;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end else begin
            r_c   <= w_res[LIMB];
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Scoreboard bench for mod_addsub_serial: three instances (256/64, 64/64,
// 256/32). Drivers push expected results into per-instance queues; monitors
// pop and compare on each output handshake and check result latency.
module tb_mod_addsub_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] ALL1 = '1;

  // Instance 0: defaults 256/64
  logic iv0 = 1'b0, sub0 = 1'b0, or0 = 1'b1;
  logic ir0, ov0, busy0;
  logic [255:0] a0 = '0, b0 = '0, m0 = '0;
  logic [255:0] d0;
  // Instance 1: 64/64
  logic iv1 = 1'b0, sub1 = 1'b0, or1 = 1'b1;
  logic ir1, ov1, busy1;
  logic [63:0] a1 = '0, b1 = '0, m1 = '0;
  logic [63:0] d1;
  // Instance 2: 256/32
  logic iv2 = 1'b0, sub2 = 1'b0, or2 = 1'b1;
  logic ir2, ov2, busy2;
  logic [255:0] a2 = '0, b2 = '0, m2 = '0;
  logic [255:0] d2;

  mod_addsub_serial #(.WIDTH(256), .LIMB(64)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .op_sub(sub0),
    .opA(a0), .opB(b0), .opM(m0), .out_valid(ov0), .out_ready(or0),
    .out_data(d0), .busy(busy0));

  mod_addsub_serial #(.WIDTH(64), .LIMB(64)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op_sub(sub1),
    .opA(a1), .opB(b1), .opM(m1), .out_valid(ov1), .out_ready(or1),
    .out_data(d1), .busy(busy1));

  mod_addsub_serial #(.WIDTH(256), .LIMB(32)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .op_sub(sub2),
    .opA(a2), .opB(b2), .opM(m2), .out_valid(ov2), .out_ready(or2),
    .out_data(d2), .busy(busy2));

  typedef struct {
    logic [255:0] d;
    int unsigned  cyc;
  } exp_t;
  exp_t q0[$], q1[$], q2[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic give_up(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
    summary();
  endtask

  // Reference: plain modular arithmetic on wide integers.
  function automatic logic [255:0] refm(input logic sub, input logic [255:0] a,
                                        input logic [255:0] b, input logic [255:0] m);
    logic [256:0] s;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end else if (a >= b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return s[255:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r = {r[223:0], $urandom()};
    return r;
  endfunction

  task automatic gen(input int unsigned w, output logic [255:0] a,
                     output logic [255:0] b, output logic [255:0] m);
    logic [255:0] mask;
    mask = (w == 256) ? ALL1 : (ALL1 >> (256 - w));
    case ($urandom_range(0, 3))
      0:       m = rnd256() & mask;
      1:       m = rnd256() & 256'hFFFF;
      2:       m = mask - (rnd256() & 256'hFF);
      default: m = (rnd256() & mask) >> $urandom_range(0, w - 1);
    endcase
    if (m == '0) m = 256'd1;
    a = (rnd256() & mask) % m;
    b = (rnd256() & mask) % m;
    if ($urandom_range(0, 7) == 0) begin
      a = m - 256'd1;
      b = m - 256'd1;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input int which, input logic sub, input logic [255:0] a,
                       input logic [255:0] b, input logic [255:0] m,
                       input logic [255:0] exp);
    bit ok;
    ok = 1'b0;
    case (which)
      0:       begin iv0 = 1'b1; sub0 = sub; a0 = a; b0 = b; m0 = m; end
      1:       begin iv1 = 1'b1; sub1 = sub; a1 = a[63:0]; b1 = b[63:0]; m1 = m[63:0]; end
      default: begin iv2 = 1'b1; sub2 = sub; a2 = a; b2 = b; m2 = m; end
    endcase
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      case (which)
        0:       ok = ir0;
        1:       ok = ir1;
        default: ok = ir2;
      endcase
      if (!ok) @(posedge clk);
    end
    if (!ok) give_up("accept_timeout");
    @(posedge clk);
    #1;
    case (which)
      0:       begin q0.push_back('{exp, cyc}); iv0 = 1'b0; end
      1:       begin q1.push_back('{exp, cyc}); iv1 = 1'b0; end
      default: begin q2.push_back('{exp, cyc}); iv2 = 1'b0; end
    endcase
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (q0.size() + q1.size() + q2.size()) != 0; n++)
      @(posedge clk);
    #1;
    chk("drain", 256'(q0.size() + q1.size() + q2.size()), 256'd0);
  endtask

  // Monitors: latency at out_valid rise, data at the handshake.
  logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ov0 && !pv0) begin
        if (q0.size() == 0) chk("spurious0", 256'(ov0), 256'd0);
        else                chk("lat0", 256'(cyc - q0[0].cyc), 256'd8);
      end
      if (ov0 && or0 && q0.size() != 0) begin
        chk("data0", d0, q0[0].d);
        void'(q0.pop_front());
      end
      if (ov1 && !pv1) begin
        if (q1.size() == 0) chk("spurious1", 256'(ov1), 256'd0);
        else                chk("lat1", 256'(cyc - q1[0].cyc), 256'd2);
      end
      if (ov1 && or1 && q1.size() != 0) begin
        chk("data1", {192'd0, d1}, q1[0].d);
        void'(q1.pop_front());
      end
      if (ov2 && !pv2) begin
        if (q2.size() == 0) chk("spurious2", 256'(ov2), 256'd0);
        else                chk("lat2", 256'(cyc - q2[0].cyc), 256'd16);
      end
      if (ov2 && or2 && q2.size() != 0) begin
        chk("data2", d2, q2[0].d);
        void'(q2.pop_front());
      end
    end
    pv0 = ov0;
    pv1 = ov1;
    pv2 = ov2;
  end

  initial begin
    logic [255:0] ra, rb, rm;
    bit ok;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(ir0), 256'd1);
    chk("rst_out_valid", 256'(ov0), 256'd0);
    chk("rst_out_data", d0, 256'd0);
    chk("rst_busy", 256'(busy0), 256'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Add / sub mod 97
    issue(0, 1'b0, 256'd50, 256'd60, 256'd97, 256'd13);
    issue(0, 1'b0, 256'd96, 256'd96, 256'd97, 256'd95);
    issue(0, 1'b0, 256'd0,  256'd0,  256'd97, 256'd0);
    issue(0, 1'b1, 256'd10, 256'd20, 256'd97, 256'd87);
    issue(0, 1'b1, 256'd20, 256'd10, 256'd97, 256'd10);
    issue(0, 1'b1, 256'd42, 256'd42, 256'd97, 256'd0);
    // Carry out of the top limb, borrow wrap, cross-limb carry
    issue(0, 1'b0, ALL1 - 256'd1, ALL1 - 256'd1, ALL1, ALL1 - 256'd2);
    issue(0, 1'b1, 256'd0, ALL1 - 256'd1, ALL1, 256'd1);
    issue(0, 1'b0, 256'hFFFF_FFFF_FFFF_FFFF, 256'd1, 256'd1 << 200, 256'd1 << 64);
    drain();

    // Backpressure: hold out_ready low with in_valid pulses during DONE
    or0 = 1'b0;
    issue(0, 1'b0, 256'd70, 256'd40, 256'd97, 256'd13);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = ov0;
    end
    if (!ok) give_up("bp_wait_valid");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      iv0 = k[0]; sub0 = 1'b0; a0 = 256'd5; b0 = 256'd6; m0 = 256'd97;
      @(negedge clk);
      chk("bp_valid", 256'(ov0), 256'd1);
      chk("bp_data", d0, 256'd13);
      chk("bp_in_ready", 256'(ir0), 256'd0);
      chk("bp_busy", 256'(busy0), 256'd1);
    end
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    or0 = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid", 256'(ov0), 256'd0);
    chk("hs_in_ready", 256'(ir0), 256'd1);
    chk("hs_data_hold", d0, 256'd13);
    issue(0, 1'b1, 256'd5, 256'd7, 256'd97, 256'd95);
    drain();

    // Reset in the third PASS1 cycle discards the operation
    issue(0, 1'b0, 256'd11, 256'd22, 256'd97, 256'd33);
    @(posedge clk);
    #1;
    chk("mid_busy", 256'(busy0), 256'd1);
    chk("mid_in_ready", 256'(ir0), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_in_ready", 256'(ir0), 256'd1);
    chk("mrst_out_valid", 256'(ov0), 256'd0);
    chk("mrst_out_data", d0, 256'd0);
    chk("mrst_busy", 256'(busy0), 256'd0);
    issue(0, 1'b0, 256'd1, 256'd2, 256'd97, 256'd3);
    drain();

    // Parameter sweep: WIDTH=LIMB=64 and WIDTH=256/LIMB=32
    for (int k = 0; k < 1000; k++) begin
      gen(64, ra, rb, rm);
      issue(1, k[0], ra, rb, rm, refm(k[0], ra, rb, rm));
    end
    drain();
    for (int k = 0; k < 1000; k++) begin
      gen(256, ra, rb, rm);
      issue(2, k[0], ra, rb, rm, refm(k[0], ra, rb, rm));
    end
    drain();

    summary();
  end

endmodule
